// File: rtl/sar_compare_ctrl.sv
// rtl/sar_compare_ctrl.sv - successive-approximation search driving a magnitude comparator's b operand
// Optional early exit on an exact match when SAR_EARLY_EXIT_EN is defined.
module sar_compare_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         lesser,
   input  logic         greater,
   input  logic         equal,
   output logic [N-1:0] guess,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE = N'(1);
   localparam logic [N-1:0] MSB = ONE << (N - 1);
   localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  guess_q, guess_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  result_q, result_d;
   logic          err_q, err_d;

   logic          flags_valid;
   logic          keep_bit;
   logic [N-1:0]  acc_next;

   // Exactly one of the three comparator flags must be set.
   assign flags_valid = (lesser ^ greater ^ equal) & ~(lesser & greater & equal);
   assign keep_bit    = greater | equal;
   assign acc_next    = keep_bit ? guess_q : acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         guess_q  <= '0;
         acc_q    <= '0;
         idx_q    <= IDX_TOP;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SEARCH;
               acc_d   = '0;
               idx_d   = IDX_TOP;
               guess_d = MSB;
               err_d   = 1'b0;
            end
         end
         ST_SEARCH: begin
            if (!flags_valid) begin
               err_d    = 1'b1;
               result_d = acc_q;
               state_d  = ST_DONE;
            end
`ifdef SAR_EARLY_EXIT_EN
            else if (equal) begin
               result_d = guess_q;
               state_d  = ST_DONE;
            end
`endif
            else if (idx_q == '0) begin
               result_d = acc_next;
               state_d  = ST_DONE;
            end else begin
               // Next trial keeps the decided bits and sets the next lower one.
               idx_d   = idx_q - 1'b1;
               guess_d = acc_next | (ONE << (idx_q - 1'b1));
               acc_d   = acc_next;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign guess  = guess_q;
   assign busy   = (state_q == ST_SEARCH);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_sar_compare_ctrl.sv
// tb/tb_sar_compare_ctrl.sv - directed self-checking bench for sar_compare_ctrl (N=8)
module tb_sar_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_val = 8'h00;
    logic       force_bad = 1'b0;
    logic       lesser, greater, equal;
    logic [7:0] guess, result;
    logic       busy, done, err;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    always #5 clk = ~clk;

    assign lesser  = force_bad ? 1'b1 : (a_val < guess);
    assign greater = force_bad ? 1'b1 : (a_val > guess);
    assign equal   = force_bad ? 1'b0 : (a_val == guess);

    sar_compare_ctrl #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .lesser  (lesser),
        .greater (greater),
        .equal   (equal),
        .guess   (guess),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_search(input logic [7:0] a, input int k, input logic [63:0] seq,
                              input bit chk_seq, input bit pulse_busy);
        a_val = a;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (chk_seq) chk("guess_seq", guess, seq[63-8*i -: 8]);
            chk("busy_in_search", busy, 1'b1);
            chk("done_low_in_search", done, 1'b0);
            start = (pulse_busy && i == 2);
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("result", result, a);
        chk("err_clear", err, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("idle_not_busy", busy, 1'b0);
        chk("result_held", result, a);
    endtask

    initial begin
        #200000;
        n_bad++;
        $error("FAIL timeout: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #12;
        chk("rst_guess", guess, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_guess", guess, 8'h00);

        run_search(8'hA5, 8, 64'h80C0A0B0A8A4A6A5, 1'b1, 1'b1);
        run_search(8'h00, 8, 64'h8040201008040201, 1'b1, 1'b0);
        run_search(8'hFF, 8, 64'h80C0E0F0F8FCFEFF, 1'b1, 1'b0);
        run_search(8'h80, EE ? 1 : 8, 64'h80C0A09088848281, 1'b1, 1'b0);
        chk("guess_holds_in_idle", guess, EE ? 8'h80 : 8'h81);

        a_val = 8'hA5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_c1", guess, 8'h80);
        @(negedge clk);
        chk("err_c2", guess, 8'hC0);
        @(negedge clk);
        chk("err_c3", guess, 8'hA0);
        force_bad = 1'b1;
        @(negedge clk);
        force_bad = 1'b0;
        chk("err_done", done, 1'b1);
        chk("err_flag", err, 1'b1);
        chk("err_result", result, 8'h80);
        @(negedge clk);
        chk("err_held", err, 1'b1);
        chk("err_done_drop", done, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared_on_start", err, 1'b0);
        chk("restart_guess", guess, 8'h80);
        repeat (8) @(negedge clk);
        chk("after_err_result", result, 8'hA5);
        chk("after_err_done", done, 1'b1);

        @(negedge clk);
        a_val = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_guess", guess, 8'h30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_guess", guess, 8'h00);
        chk("arst_result", result, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        @(negedge clk);
        chk("arst_hold_busy", busy, 1'b0);
        rst_n = 1'b1;
        run_search(8'hA5, 8, 64'h80C0A0B0A8A4A6A5, 1'b1, 1'b0);

        a_val = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < (EE ? 6 : 8); i++) begin
                chk("b2b_guess", guess, (i == 0) ? 8'h80 : (i == 1) ? 8'h40 : (i == 2) ? 8'h20 :
                                        (i == 3) ? 8'h30 : (i == 4) ? 8'h38 : (i == 5) ? 8'h3C :
                                        (i == 6) ? 8'h3E : 8'h3D);
                chk("b2b_busy", busy, 1'b1);
                @(negedge clk);
            end
            chk("b2b_done", done, 1'b1);
            chk("b2b_result", result, 8'h3C);
            @(negedge clk);
            chk("b2b_idle", busy, 1'b0);
            @(negedge clk);
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_compare_ctrl.md
Name: sar_compare_ctrl

Overview:
- Initiator side of the N-bit magnitude comparator interface. The comparator compares an unknown operand `a` against operand `b`, and this block drives `b`.
- It reads back the comparator's lesser/greater/equal flags and runs a successive-approximation (MSB-first binary) search to recover `a`.
- One compare per clock; the comparator path between `guess` and the flags is purely combinational.
- Used as the digital back end of SAR-style converters and for threshold search.

Parameters:
- N, 8, operand width in bits; range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  search request; sampled in IDLE only
- lesser  input  1  comparator flag: a < guess
- greater  input  1  comparator flag: a > guess
- equal  input  1  comparator flag: a == guess
- guess  output  N  trial value, drives comparator operand b
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse when result is valid
- result  output  N  recovered value of a; held until next start
- err  output  1  invalid flag combination seen during last search; held until next start

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; guess=0; result=0; busy=0; done=0; err=0.
  - Internal accumulator acc=0; bit index idx=N-1.
  - Reset asserted mid-search aborts immediately. No done pulse; result returns to 0.
- All state is registered on the clk rising edge. Flags are sampled in the same cycle `guess` is presented.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - When start=1, go to SEARCH.
  - On entry to SEARCH: acc=0, idx=N-1, guess=1<<(N-1), err=0, busy=1.
  - When start=0, hold; guess holds its last value.
- SEARCH (one compare per cycle):
  - Flags are valid when exactly one of lesser/greater/equal is 1.
  - Invalid combination (zero or more than one flag set): err=1, result=acc, go to DONE.
  - Otherwise keep_bit = greater|equal, and acc_next = keep_bit ? guess : acc.
  - If idx==0: result=acc_next, go to DONE.
  - Else: idx=idx-1, guess=acc_next | (1<<(idx-1)), acc=acc_next.
- DONE:
  - busy=0, done=1 for exactly this one cycle, then IDLE.
  - start is ignored in DONE; start held high re-triggers from IDLE on the following cycle.
- start asserted while busy: ignored; it does not restart or extend the search.
- Latency without early exit:
  - start sampled at cycle 0; compares occur in cycles 1..N; done high at cycle N+1.
  - Next start accepted at cycle N+2.
- Arithmetic: unsigned only. No wrap-around is possible, since guess never exceeds 2^N-1 (guess is always acc with one more bit set).
- Exact recovery: for any consistent comparator, result equals a at done.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN
- Defined:
  - In SEARCH, a valid equal=1 with lesser=0 and greater=0 sets result=guess and goes to DONE at once.
  - Latency is then k+1 cycles from start to done, where k is the number of compares performed (1..N).
- Undefined:
  - equal is treated only as keep_bit; the search always performs N compares.
  - Final result is identical either way; only latency differs.

Test Plan:
- Model comparator with a=8'hA5, N=8, pulse start -> guess sequence 80,C0,A0,B0,A8,A4,A6,A5; done at cycle 9; result=8'hA5; err=0.
- a=8'h00 -> all compares lesser; guess 80,40,...,01; result=8'h00 after 8 compares. Repeat with a=8'hFF -> result=8'hFF.
- SAR_EARLY_EXIT_EN defined, a=8'h80 -> first compare equal; done at cycle 2; result=8'h80. Macro undefined -> done at cycle 9, result=8'h80.
- Force lesser=1 and greater=1 on the 3rd compare -> err=1, done pulse the next cycle, result=8'h80 (acc at abort for a=8'hA5). err clears on the next start.
- Drop rst_n low during the 4th compare -> guess/result/busy/done/err all 0 asynchronously, FSM in IDLE. A new start after release runs a full correct search.
- start held high continuously with a=8'h3C -> back-to-back searches, each result=8'h3C. start pulses during busy have no effect on the guess sequence.
